// File: rtl/rf_wb_pkg.sv
// Shared types and default sizing for the register-file writeback controller.
// No logic; latency and backpressure are defined by the modules that import it.
package rf_wb_pkg;

   localparam int unsigned DEF_WORD_SIZE           = 32;
   localparam int unsigned DEF_NUMBER_OF_REGISTERS = 32;
   localparam int unsigned DEF_DEPTH               = 4;

   function automatic int unsigned addr_width(input int unsigned n_regs);
      return (n_regs > 1) ? $clog2(n_regs) : 1;
   endfunction

   localparam int unsigned DEF_ADDR_WIDTH = addr_width(DEF_NUMBER_OF_REGISTERS);

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_WORD_SIZE-1:0]  data;
   } wb_entry_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Producer request, register-file write and forwarding signals of rf_writeback_ctrl.
// Slave = controller view; master = producers, register file and forwarding consumer.
interface rf_writeback_ctrl_if
   import rf_wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [WORD_SIZE-1:0]  req0_data;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [WORD_SIZE-1:0]  req1_data;
   logic                  RegWrite;
   logic [ADDR_WIDTH-1:0] WriteReg;
   logic [WORD_SIZE-1:0]  WriteData;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] fwd_addr;
   logic                  fwd_hit;
   logic [WORD_SIZE-1:0]  fwd_data;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  fwd_addr,
      output req0_ready, req1_ready,
      output RegWrite, WriteReg, WriteData, busy,
      output fwd_hit, fwd_data
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output fwd_addr,
      input  req0_ready, req1_ready,
      input  RegWrite, WriteReg, WriteData, busy,
      input  fwd_hit, fwd_data
   );

endinterface

// File: rtl/rf_wb_fifo.sv
// DEPTH-entry FIFO of write entries; push is visible at head the cycle after the push edge.
// No internal guard: caller never pushes when full or pops when empty. Entries exposed oldest-first.
module rf_wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter type entry_t = wb_entry_t,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  entry_t                 push_dat,
   input  logic                   pop,
   output entry_t                 head_dat,
   output logic [CNT_W-1:0]       count,
   output entry_t [DEPTH-1:0]     age_dat,
   output logic [DEPTH-1:0]       age_vld
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Index 0 is the oldest entry; pointer arithmetic wraps at DEPTH (power of two).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_dat[i] = mem_q[rd_ptr_q + PTR_W'(i)];
         age_vld[i] = CNT_W'(i) < count_q;
      end
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Two-producer register-file write master: accept -> FIFO -> registered RegWrite one edge later; 1 write/cycle.
// Round-robin ready on contention, ready=0 when FIFO full; forwarding enabled by macro RF_WB_FORWARD_EN.
module rf_writeback_ctrl
   import rf_wb_pkg::*;
#(
   parameter int unsigned WORD_SIZE           = DEF_WORD_SIZE,
   parameter int unsigned NUMBER_OF_REGISTERS = DEF_NUMBER_OF_REGISTERS,
   parameter int unsigned DEPTH               = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   rf_writeback_ctrl_if.slave  bus
);
   localparam int unsigned ADDR_WIDTH = addr_width(NUMBER_OF_REGISTERS);
   localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [WORD_SIZE-1:0]  data;
   } entry_t;

   logic                  rr_ptr_q, rr_ptr_d;
   logic                  regwrite_q, regwrite_d;
   logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
   logic [WORD_SIZE-1:0]  write_data_q, write_data_d;

   logic [CNT_W-1:0]      count;
   logic                  not_full;
   logic                  fifo_empty;
   logic                  rdy0, rdy1;
   logic                  grant0, grant1;
   logic                  push, pop;
   entry_t                acc_dat;
   entry_t                head_dat;
   entry_t [DEPTH-1:0]    age_dat;
   logic [DEPTH-1:0]      age_vld;

   assign not_full   = count < CNT_W'(DEPTH);
   assign fifo_empty = count == '0;

   // Ready looks only at the registered count, so a full FIFO blocks even on a popping cycle.
   always_comb begin
      rdy0     = not_full && (!bus.req1_valid || !rr_ptr_q);
      rdy1     = not_full && (!bus.req0_valid ||  rr_ptr_q);
      grant0   = bus.req0_valid && rdy0;
      grant1   = bus.req1_valid && rdy1;
      rr_ptr_d = rr_ptr_q;
      if (bus.req0_valid && bus.req1_valid && not_full) begin
         rr_ptr_d = !rr_ptr_q;
      end
      acc_dat.addr = grant1 ? bus.req1_addr : bus.req0_addr;
      acc_dat.data = grant1 ? bus.req1_data : bus.req0_data;
      // r0 writes complete the handshake but are dropped here.
      push = (grant0 || grant1) && (acc_dat.addr != '0);
   end

   always_comb begin
      pop          = !fifo_empty;
      regwrite_d   = !fifo_empty;
      write_reg_d  = fifo_empty ? write_reg_q  : head_dat.addr;
      write_data_d = fifo_empty ? write_data_q : head_dat.data;
   end

   rf_wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (acc_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .count    (count),
      .age_dat  (age_dat),
      .age_vld  (age_vld)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= 1'b0;
         regwrite_q   <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         regwrite_q   <= regwrite_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.RegWrite   = regwrite_q;
   assign bus.WriteReg   = write_reg_q;
   assign bus.WriteData  = write_data_q;
   assign bus.busy       = !fifo_empty || regwrite_q;

`ifdef RF_WB_FORWARD_EN
   // Scan oldest to youngest so the youngest match overrides; output stage is oldest of all.
   always_comb begin
      bus.fwd_hit  = 1'b0;
      bus.fwd_data = '0;
      if (bus.fwd_addr != '0) begin
         if (regwrite_q && (write_reg_q == bus.fwd_addr)) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = write_data_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (age_vld[i] && (age_dat[i].addr == bus.fwd_addr)) begin
               bus.fwd_hit  = 1'b1;
               bus.fwd_data = age_dat[i].data;
            end
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd   = ^{bus.fwd_addr, age_dat, age_vld};
   assign bus.fwd_hit  = 1'b0;
   assign bus.fwd_data = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Randomized two-producer bench for rf_writeback_ctrl against a queue-based reference model,
// with directed scenarios pinning latency, arbitration order, r0 drop, reset and forwarding.
module tb_rf_writeback_ctrl;
   import rf_wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 5;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rf_writeback_ctrl_if #(.ADDR_WIDTH(AW), .WORD_SIZE(32)) bus ();

   rf_writeback_ctrl #(
      .WORD_SIZE           (32),
      .NUMBER_OF_REGISTERS (32),
      .DEPTH               (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: pending writes in arrival order plus the visible write stage.
   wr_t           pend[$];
   logic          m_rw;
   logic [AW-1:0] m_wr;
   logic [31:0]   m_wd;
   bit            m_rr;
   bit            g0, g1;
   wr_t           wlog[$];
   logic [31:0]   rf [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      m_rw = 1'b0;
      m_wr = '0;
      m_wd = '0;
      m_rr = 1'b0;
   endtask

   task automatic compare_outputs();
      int          owner;
      bit          exp_hit;
      logic [31:0] exp_fd;
      if (bus.req0_valid && bus.req1_valid) owner = int'(m_rr);
      else if (bus.req0_valid)              owner = 0;
      else if (bus.req1_valid)              owner = 1;
      else                                  owner = -1;
      if (pend.size() >= DEPTH) owner = -1;
      if (bus.req0_valid) chk("ready0", 32'(bus.req0_ready), 32'(owner == 0));
      if (bus.req1_valid) chk("ready1", 32'(bus.req1_ready), 32'(owner == 1));
      chk("regwrite", 32'(bus.RegWrite), 32'(m_rw));
      chk("writereg", 32'(bus.WriteReg), 32'(m_wr));
      chk("writedata", bus.WriteData, m_wd);
      chk("busy", 32'(bus.busy), 32'(pend.size() != 0 || m_rw));
      exp_hit = 1'b0;
      exp_fd  = '0;
`ifdef RF_WB_FORWARD_EN
      if (bus.fwd_addr != '0) begin
         if (m_rw && m_wr == bus.fwd_addr) begin
            exp_hit = 1'b1;
            exp_fd  = m_wd;
         end
         foreach (pend[i]) begin
            if (pend[i].addr == bus.fwd_addr) begin
               exp_hit = 1'b1;
               exp_fd  = pend[i].data;
            end
         end
      end
`endif
      chk("fwd_hit", 32'(bus.fwd_hit), 32'(exp_hit));
      chk("fwd_data", bus.fwd_data, exp_fd);
      if (bus.RegWrite === 1'b1) begin
         wlog.push_back(wr_t'{bus.WriteReg, bus.WriteData});
         rf[bus.WriteReg] = bus.WriteData;
      end
      g0 = bus.req0_valid && owner == 0;
      g1 = bus.req1_valid && owner == 1;
   endtask

   task automatic advance();
      wr_t e;
      if (bus.req0_valid && bus.req1_valid && (g0 || g1)) m_rr = !m_rr;
      if (pend.size() > 0) begin
         e    = pend.pop_front();
         m_rw = 1'b1;
         m_wr = e.addr;
         m_wd = e.data;
      end else begin
         m_rw = 1'b0;
      end
      if (g0 && bus.req0_addr != '0) pend.push_back(wr_t'{bus.req0_addr, bus.req0_data});
      if (g1 && bus.req1_addr != '0) pend.push_back(wr_t'{bus.req1_addr, bus.req1_data});
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      advance();
      #1;
   endtask

   initial begin
      int n0, n1;
      int ord[$];
      int exp_ord[4];
      int exp_adr[4];
      int exp_dat[4];
      exp_ord = '{0, 1, 0, 1};
      exp_adr = '{1, 11, 2, 12};
      exp_dat = '{32'h1001, 32'h100B, 32'h1002, 32'h100C};
      for (int i = 0; i < 32; i++) rf[i] = '0;

      bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
      bus.fwd_addr   = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
      chk("rst_writereg", 32'(bus.WriteReg), 32'd0);
      chk("rst_writedata", bus.WriteData, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);

      // Single write, one-cycle latency from accept to RegWrite.
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEADBEEF;
      cycle();
      chk("t1_accept", 32'(g0), 32'd1);
      bus.req0_valid = 1'b0;
      chk("t1_rw_early", 32'(bus.RegWrite), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      cycle();
      chk("t1_rw", 32'(bus.RegWrite), 32'd1);
      chk("t1_wreg", 32'(bus.WriteReg), 32'd5);
      chk("t1_wdata", bus.WriteData, 32'hDEADBEEF);
      cycle();
      chk("t1_rf5", rf[5], 32'hDEADBEEF);

      // Contention: alternating grants starting with producer 0.
      wlog.delete();
      n0 = 1; n1 = 11;
      repeat (4) begin
         bus.req0_valid = 1'b1; bus.req0_addr = AW'(n0); bus.req0_data = 32'h1000 + n0;
         bus.req1_valid = 1'b1; bus.req1_addr = AW'(n1); bus.req1_data = 32'h1000 + n1;
         cycle();
         if (g0) begin ord.push_back(0); n0++; end
         if (g1) begin ord.push_back(1); n1++; end
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      repeat (3) cycle();
      chk("t2_grants", 32'(ord.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < ord.size()) chk("t2_order", 32'(ord[i]), 32'(exp_ord[i]));
      end
      chk("t2_writes", 32'(wlog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wlog.size()) begin
            chk("t2_waddr", 32'(wlog[i].addr), 32'(exp_adr[i]));
            chk("t2_wdata", wlog[i].data, 32'(exp_dat[i]));
         end
      end

      // r0 write is acknowledged but never reaches the register file.
      bus.req1_valid = 1'b1; bus.req1_addr = '0; bus.req1_data = 32'h1234;
      cycle();
      chk("t4_accept", 32'(g1), 32'd1);
      bus.req1_valid = 1'b0;
      repeat (3) begin
         chk("t4_busy", 32'(bus.busy), 32'd0);
         chk("t4_rw", 32'(bus.RegWrite), 32'd0);
         cycle();
      end

      // Forwarding: youngest of two pending r9 writes.
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'h11;
      cycle();
      bus.req0_data = 32'h22;
      cycle();
      bus.req0_valid = 1'b0;
      bus.fwd_addr = 5'd9;
      #1;
`ifdef RF_WB_FORWARD_EN
      chk("t6_hit", 32'(bus.fwd_hit), 32'd1);
      chk("t6_data", bus.fwd_data, 32'h22);
`else
      chk("t6_hit", 32'(bus.fwd_hit), 32'd0);
      chk("t6_data", bus.fwd_data, 32'd0);
`endif
      bus.fwd_addr = '0;
      #1;
      chk("t6_hit_r0", 32'(bus.fwd_hit), 32'd0);
      repeat (3) cycle();

      // Reset in the middle of draining two r7 writes.
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'hA;
      cycle();
      bus.req0_data = 32'hB;
      cycle();
      bus.req0_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("t5_rw", 32'(bus.RegWrite), 32'd0);
      chk("t5_wreg", 32'(bus.WriteReg), 32'd0);
      chk("t5_wdata", bus.WriteData, 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) begin
         cycle();
         chk("t5_no_write", 32'(bus.RegWrite), 32'd0);
      end

      // Random traffic; a producer holds its request until it is granted.
      g0 = 1'b0; g1 = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!bus.req0_valid || g0) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req0_addr  = AW'($urandom_range(0, 7));
            bus.req0_data  = $urandom;
         end
         if (!bus.req1_valid || g1) begin
            bus.req1_valid = ($urandom_range(0, 3) != 0);
            bus.req1_addr  = AW'($urandom_range(0, 7));
            bus.req1_data  = $urandom;
         end
         bus.fwd_addr = AW'($urandom_range(0, 7));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
